uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_receiver_sync_2ff.sv | 24 ++
 rtl/uart_receiver.sv | 177 +++++++++++++++++
 tb/tb_uart_receiver.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, framing constants and baud helpers
package uart_pkg;

  // Receiver/transmitter state encoding shared by both directions of the link.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  // Clocks per bit, truncated exactly like the transmitter computes it so both ends agree.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Even-parity bit for one data byte (the bit that makes the total count of ones even).
  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// rtl/uart_receiver_sync_2ff.sv - generic two-flop synchronizer with selectable reset level
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the first may go metastable, the second gives it a cycle to settle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive stage; define UART_RX_PARITY_EN for an even-parity bit and parity_err
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_START     = START;
  localparam logic [2:0] ST_DATA      = DATA;
  localparam logic [2:0] ST_STOP      = STOP;
  localparam logic [2:0] ST_WAIT_IDLE = WAIT_IDLE;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY    = PARITY;
  localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
  localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif

  logic                 rx_s;
  logic [2:0]           state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 baud_tick;
  logic                 half_tick;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit;
  logic                 parity_ok;
`endif

  sync_2ff #(
    .RST_VAL (IDLE_LEVEL)
  ) u_rx_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  assign baud_tick = (baud_cnt == BIT_LAST);
  assign half_tick = (baud_cnt == HALF_LAST);
  assign busy      = (state != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_ok = (even_parity(shift_reg) == parity_bit);
`endif

  // Frame FSM: start-bit qualification at mid-bit, centre sampling of data/stop, single-cycle result pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data_out   <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (rx_s != IDLE_LEVEL) begin
            state    <= ST_START;
            baud_cnt <= '0;
          end
        end

        ST_START: begin
          if (half_tick) begin
            baud_cnt <= '0;
            if (rx_s != IDLE_LEVEL) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              // Line went back high before mid-bit: a glitch, not a start bit.
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_tick) begin
            baud_cnt           <= '0;
            shift_reg[bit_idx] <= rx_s;
            if (bit_idx == LAST_IDX) begin
              state <= ST_AFTER_DATA;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            baud_cnt   <= '0;
            parity_bit <= rx_s;
            state      <= ST_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (baud_tick) begin
            baud_cnt <= '0;
            if (rx_s == IDLE_LEVEL) begin
              // Good stop bit: the line is idle now, so a new start edge can be taken next cycle.
              state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              if (parity_ok) begin
                data_out <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                parity_err <= 1'b1;
              end
`else
              data_out <= shift_reg;
              rx_valid <= 1'b1;
`endif
            end else begin
              frame_err <= 1'b1;
              state     <= ST_WAIT_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        ST_WAIT_IDLE: begin
          // A low line after a bad stop bit is a break, not a new start bit.
          if (rx_s == IDLE_LEVEL) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed scoreboard bench for uart_receiver
module tb_uart_receiver;

  localparam int CPB = 868;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + 434 + 8 * 868 + 868 + 868 + 1 - 1;
`else
  localparam int LAT = 2 + 434 + 8 * 868 + 868 + 1 - 1;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  logic       par_flip = 1'b0;
  int         perr_hi = 0;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int valid_hi = 0;
  int ferr_hi = 0;
  int both_hi = 0;
  int last_valid_cyc = 0;
  int n_sent = 0;
  int t0 = 0;
  int v0 = 0;
  int lat = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rcv_q[$];

  uart_receiver #(
    .CLK_FREQ  (100_000_000),
    .BAUD_RATE (115200)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .data_out   (data_out),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: capture each received byte and count every pulse cycle, away from the active edge.
  always @(negedge clock) begin
    if (rx_valid) begin
      valid_hi++;
      rcv_q.push_back(data_out);
      last_valid_cyc = cyc;
    end
    if (frame_err) ferr_hi++;
    if (rx_valid && frame_err) both_hi++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_hi++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    tick(CPB);
  endtask

  task automatic send(input logic [7:0] b, input logic stop_v);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_v);
  endtask

  task automatic push_send(input logic [7:0] b);
    exp_q.push_back(b);
    n_sent++;
    send(b, 1'b1);
  endtask

  task automatic expect_byte(input string tag);
    int w;
    w = 0;
    while (rcv_q.size() == 0 && w < 3 * CPB) begin
      tick(1);
      w++;
    end
    if (rcv_q.size() == 0 || exp_q.size() == 0) begin
      check({tag, "_timeout"}, 32'(rcv_q.size()), 32'(exp_q.size() > 0 ? 1 : 0) + 32'd100);
    end else begin
      check(tag, 32'(rcv_q.pop_front()), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    // Reset state
    reset_n = 1'b0;
    tick(3);
    check("rst_data_out", 32'(data_out), 32'h00);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick(5);

    // Glitch shorter than half a bit
    rx = 1'b0;
    tick(100);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    tick(100);
    rx = 1'b1;
    tick(600);
    check("glitch_busy_lo", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(valid_hi), 32'd0);
    check("glitch_no_ferr", 32'(ferr_hi), 32'd0);

    // Framing error followed by a held-low line, then recovery
    send(8'hA5, 1'b0);
    tick(3000);
    check("ferr_pulse", 32'(ferr_hi), 32'd1);
    check("ferr_data_held", 32'(data_out), 32'h00);
    check("ferr_no_valid", 32'(valid_hi), 32'd0);
    check("ferr_wait_idle_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    tick(10);
    check("ferr_back_idle", 32'(busy), 32'd0);
    tick(CPB);
    push_send(8'h3C);
    expect_byte("recover_3c");
    check("recover_ferr_once", 32'(ferr_hi), 32'd1);

    // Single byte with latency measurement
    tick(CPB);
    t0 = cyc;
    push_send(8'h48);
    expect_byte("single_48");
    lat = last_valid_cyc - t0;
    check("latency_window", 32'((lat >= LAT - 1) && (lat <= LAT + 1)), 32'd1);
    check("single_data_out", 32'(data_out), 32'h48);

    // Reset in the middle of bit 4 of 0xFF
    tick(CPB);
    v0 = valid_hi;
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(4 * CPB + CPB / 2);
    reset_n = 1'b0;
    tick(2);
    check("midrst_data_out", 32'(data_out), 32'h00);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rx_valid", 32'(rx_valid), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    tick(5);
    reset_n = 1'b1;
    tick(2 * CPB);
    check("midrst_no_pulse", 32'(valid_hi), 32'(v0));
    push_send(8'h01);
    expect_byte("after_rst_01");
    check("after_rst_data_out", 32'(data_out), 32'h01);

    // Back-to-back frames, no gap beyond the stop bit
    push_send(8'h55);
    push_send(8'h00);
    push_send(8'h80);
    expect_byte("b2b_55");
    expect_byte("b2b_00");
    expect_byte("b2b_80");

`ifdef UART_RX_PARITY_EN
    // Bad parity suppresses the byte, good parity delivers it
    v0 = valid_hi;
    par_flip = 1'b1;
    send(8'h07, 1'b1);
    tick(4);
    check("par_err_pulse", 32'(perr_hi), 32'd1);
    check("par_err_no_valid", 32'(valid_hi), 32'(v0));
    check("par_err_data_held", 32'(data_out), 32'h80);
    par_flip = 1'b0;
    push_send(8'h07);
    expect_byte("par_ok_07");
    check("par_ok_data_out", 32'(data_out), 32'h07);
    check("par_err_once", 32'(perr_hi), 32'd1);
`endif

    // Global invariants
    tick(10);
    check("valid_ferr_overlap", 32'(both_hi), 32'd0);
    check("valid_one_cycle_each", 32'(valid_hi), 32'(n_sent));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("ferr_total", 32'(ferr_hi), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
